// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot frame scheduler.
// The optional abort input is enabled by the MANDEL_SCHED_ABORT_EN macro.
package mandel_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_COLS   = 160;
  localparam int DEF_ROWS   = 120;
  localparam int DEF_ADDR_W = 15;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_NEXT  = 2'd3;

  typedef logic [DEF_WIDTH-1:0] coord_t;

endpackage

// File: rtl/mandel_coord_gen.sv
// Raster walker: x/y counters, linear framebuffer address and the re/im
// coordinate accumulators (addition only, wrapping modulo 2^WIDTH).
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [WIDTH-1:0]  i_start_re,
  input  logic [WIDTH-1:0]  i_start_im,
  input  logic [WIDTH-1:0]  i_step,
  output logic [WIDTH-1:0]  o_re,
  output logic [WIDTH-1:0]  o_im,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last_pixel
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [WIDTH-1:0]  r_re;
  logic [WIDTH-1:0]  r_im;
  logic [WIDTH-1:0]  r_start_re;
  logic [WIDTH-1:0]  r_step;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last_col;
  logic              w_last_pixel;

  assign w_last_col   = (r_x == XW'(COLS - 1));
  assign w_last_pixel = w_last_col && (r_y == YW'(ROWS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_re       <= '0;
      r_im       <= '0;
      r_start_re <= '0;
      r_step     <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_x        <= '0;
      r_y        <= '0;
      r_re       <= i_start_re;
      r_im       <= i_start_im;
      r_start_re <= i_start_re;
      r_step     <= i_step;
      r_addr     <= '0;
    end else if (i_advance && !w_last_pixel) begin
      // Row wrap reloads the real part from the latched window origin.
      if (w_last_col) begin
        r_x  <= '0;
        r_y  <= r_y + 1'b1;
        r_re <= r_start_re;
        r_im <= r_im + r_step;
      end else begin
        r_x  <= r_x + 1'b1;
        r_re <= r_re + r_step;
      end
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_re         = r_re;
  assign o_im         = r_im;
  assign o_addr       = r_addr;
  assign o_last_col   = w_last_col;
  assign o_last_pixel = w_last_pixel;

endmodule

// File: rtl/mandel_scheduler.sv
// Frame sequencer: walks every pixel, offers one point at a time to the
// iteration core and writes each returned count to the framebuffer.
// Define MANDEL_SCHED_ABORT_EN to add the abort input.
module mandel_scheduler
  import mandel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [WIDTH-1:0]  start_re,
  input  logic [WIDTH-1:0]  start_im,
  input  logic [WIDTH-1:0]  step,
`ifdef MANDEL_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              core_valid,
  input  logic              core_ready,
  output logic [WIDTH-1:0]  core_re,
  output logic [WIDTH-1:0]  core_im,
  input  logic              res_valid,
  input  logic [CNT_W-1:0]  res_count,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [CNT_W-1:0]  fb_data,
  output logic [1:0]        dbg_state
);

  // Core handshake: a point transfers on a rising edge where core_valid and
  // core_ready are both high; core_re/core_im hold while valid waits for ready.

  state_t            r_state;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_core_valid;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [CNT_W-1:0]  r_fb_data;
  logic              r_abort_pend;

  logic              w_abort;
  logic              w_load;
  logic              w_advance;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last_col;
  logic              w_last_pixel;

`ifdef MANDEL_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_load    = (r_state == S_IDLE) && frame_start;
  assign w_advance = (r_state == S_NEXT) && !w_abort;

  mandel_coord_gen #(
    .WIDTH  (WIDTH),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_coord (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_load       (w_load),
    .i_advance    (w_advance),
    .i_start_re   (start_re),
    .i_start_im   (start_im),
    .i_step       (step),
    .o_re         (core_re),
    .o_im         (core_im),
    .o_addr       (w_addr),
    .o_last_col   (w_last_col),
    .o_last_pixel (w_last_pixel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_core_valid <= 1'b0;
      r_fb_we      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_fb_we      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          if (frame_start) begin
            r_busy       <= 1'b1;
            r_core_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Abort wins over a same-cycle handshake; a late result is ignored in IDLE.
          if (w_abort) begin
            r_core_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else if (core_ready) begin
            r_core_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (res_valid) begin
            if (r_abort_pend || w_abort) begin
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_fb_we   <= 1'b1;
              r_fb_addr <= w_addr;
              r_fb_data <= res_count;
              r_state   <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (w_abort || w_last_pixel) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_core_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign core_valid = r_core_valid;
  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mandel_scheduler.sv
// Directed bench for mandel_scheduler on a 4x2 frame; the bench plays the
// iteration core and checks framebuffer writes against an expected queue.
module tb_mandel_scheduler;

  localparam int WIDTH  = 32;
  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int W      = ADDR_W + CNT_W;

  logic              clock;
  logic              reset_n;
  logic              frame_start;
  logic [WIDTH-1:0]  start_re;
  logic [WIDTH-1:0]  start_im;
  logic [WIDTH-1:0]  step;
  logic              busy;
  logic              frame_done;
  logic              core_valid;
  logic              core_ready;
  logic [WIDTH-1:0]  core_re;
  logic [WIDTH-1:0]  core_im;
  logic              res_valid;
  logic [CNT_W-1:0]  res_count;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [CNT_W-1:0]  fb_data;
  logic [1:0]        dbg_state;
`ifdef MANDEL_SCHED_ABORT_EN
  logic              abort;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  mandel_scheduler #(
    .WIDTH  (WIDTH),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .start_re    (start_re),
    .start_im    (start_im),
    .step        (step),
`ifdef MANDEL_SCHED_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .frame_done  (frame_done),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .core_re     (core_re),
    .core_im     (core_im),
    .res_valid   (res_valid),
    .res_count   (res_count),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_frame(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st);
    start_re    = re;
    start_im    = im;
    step        = st;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (core_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("valid_timeout", {63'd0, core_valid}, 64'd1);
  endtask

  // Acts as the core for one pixel: optional stall, optional frame_start
  // poke while busy, then returns cnt and checks the resulting write.
  task automatic serve_pixel(input logic [31:0] e_re, input logic [31:0] e_im,
                             input logic [ADDR_W-1:0] e_addr, input logic [CNT_W-1:0] cnt,
                             input int stall, input bit poke, input bit last);
    logic [W-1:0] exp_w;
    wait_valid();
    chk("core_re", core_re, e_re);
    chk("core_im", core_im, e_im);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      chk("stall_valid", {63'd0, core_valid}, 64'd1);
      chk("stall_re", core_re, e_re);
      chk("stall_im", core_im, e_im);
      chk("stall_no_we", {63'd0, fb_we}, 64'd0);
    end
    core_ready = 1'b1;
    exp_q.push_back({e_addr, cnt});
    @(negedge clock);
    core_ready = 1'b0;
    chk("hs_valid_low", {63'd0, core_valid}, 64'd0);
    if (poke) begin
      frame_start = 1'b1;
      start_re    = 32'hDEADBEEF;
      @(negedge clock);
      frame_start = 1'b0;
      chk("poke_busy", {63'd0, busy}, 64'd1);
      chk("poke_no_we", {63'd0, fb_we}, 64'd0);
    end
    res_valid = 1'b1;
    res_count = cnt;
    @(negedge clock);
    res_valid = 1'b0;
    chk("fb_we", {63'd0, fb_we}, 64'd1);
    exp_w = exp_q.pop_front();
    chk("fb_write", {52'd0, fb_addr, fb_data}, {52'd0, exp_w});
    @(negedge clock);
    chk("fb_we_pulse", {63'd0, fb_we}, 64'd0);
    chk("frame_done", {63'd0, frame_done}, {63'd0, last});
    chk("busy_after", {63'd0, busy}, {63'd0, !last});
  endtask

  initial begin
    logic [31:0] e_re;
    logic [31:0] e_im;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    start_re    = '0;
    start_im    = '0;
    step        = '0;
    core_ready  = 1'b0;
    res_valid   = 1'b0;
    res_count   = '0;
`ifdef MANDEL_SCHED_ABORT_EN
    abort       = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, core_valid}, 64'd0);
    chk("rst_we", {63'd0, fb_we}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    chk("rst_re", core_re, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Frame A: origin 0, step 0x100, counts x+10*y; stall on pixel 2, poke on pixel 1
    start_frame(32'h0, 32'h0, 32'h100);
    for (int p = 0; p < COLS * ROWS; p++) begin
      e_re = 32'(p % COLS) * 32'h100;
      e_im = 32'(p / COLS) * 32'h100;
      serve_pixel(e_re, e_im, ADDR_W'(p), CNT_W'((p % COLS) + 10 * (p / COLS)),
                  (p == 2) ? 5 : 0, p == 1, p == COLS * ROWS - 1);
    end
    @(negedge clock);
    chk("done_once", {63'd0, frame_done}, 64'd0);
    chk("idle_state", {62'd0, dbg_state}, 64'd0);

    // Frame B: real part wraps past 0x7FFFFFFF; reset during WAIT on pixel 5
    start_frame(32'h7FFFFF00, 32'h10, 32'h100);
    for (int p = 0; p < 5; p++) begin
      e_re = 32'h7FFFFF00 + 32'(p % COLS) * 32'h100;
      e_im = 32'h10 + 32'(p / COLS) * 32'h100;
      serve_pixel(e_re, e_im, ADDR_W'(p), CNT_W'(8'h40 + p), 0, 1'b0, 1'b0);
    end
    wait_valid();
    chk("p5_re", core_re, 64'h80000000);
    chk("p5_im", core_im, 64'h110);
    core_ready = 1'b1;
    @(negedge clock);
    core_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_valid", {63'd0, core_valid}, 64'd0);
    chk("mid_rst_re", core_re, 64'd0);
    chk("mid_rst_im", core_im, 64'd0);
    chk("mid_rst_addr", {60'd0, fb_addr}, 64'd0);
    chk("mid_rst_data", {56'd0, fb_data}, 64'd0);
    chk("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    res_valid = 1'b1;
    res_count = 8'h55;
    @(negedge clock);
    res_valid = 1'b0;
    chk("spurious_no_we", {63'd0, fb_we}, 64'd0);
    chk("spurious_idle", {62'd0, dbg_state}, 64'd0);
    @(negedge clock);
    chk("spurious_no_we2", {63'd0, fb_we}, 64'd0);

    // Frame C: restart from addr 0; imaginary part wraps through zero on row 1
    start_frame(32'h1000, 32'hFFFFFFF0, 32'h10);
    for (int p = 0; p < COLS * ROWS; p++) begin
      e_re = 32'h1000 + 32'(p % COLS) * 32'h10;
      e_im = 32'hFFFFFFF0 + 32'(p / COLS) * 32'h10;
      serve_pixel(e_re, e_im, ADDR_W'(p), CNT_W'(8'hF0 + p), 0, 1'b0, p == COLS * ROWS - 1);
    end

`ifdef MANDEL_SCHED_ABORT_EN
    // Frame D: abort while waiting on pixel 3
    @(negedge clock);
    start_frame(32'h0, 32'h0, 32'h100);
    for (int p = 0; p < 3; p++)
      serve_pixel(32'(p) * 32'h100, 32'h0, ADDR_W'(p), CNT_W'(p), 0, 1'b0, 1'b0);
    wait_valid();
    chk("ab_re", core_re, 64'h300);
    core_ready = 1'b1;
    @(negedge clock);
    core_ready = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort     = 1'b0;
    chk("ab_wait_busy", {63'd0, busy}, 64'd1);
    res_valid = 1'b1;
    res_count = 8'h77;
    @(negedge clock);
    res_valid = 1'b0;
    chk("ab_no_we", {63'd0, fb_we}, 64'd0);
    chk("ab_done", {63'd0, frame_done}, 64'd1);
    chk("ab_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    chk("ab_done_pulse", {63'd0, frame_done}, 64'd0);
    chk("ab_no_we2", {63'd0, fb_we}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
